// File: rtl/mux_pipe_bank_pkg.sv
// Shared types and helpers for the pipelined source-select mux bank.
package mux_pipe_pkg;

  // Number of beats currently held by the bank (main register plus skid).
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Select field width for an NIN-way mux; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned nin);
    return (nin > 1) ? unsigned'($clog2(nin)) : 1;
  endfunction

  // Select index clamped to source 0 when out of range; the caller masks data.
  function automatic int unsigned safe_sel(input int unsigned s, input int unsigned nin);
    return (s < nin) ? s : 0;
  endfunction

endpackage

// File: rtl/mux_pipe_bank_if.sv
// Handshake and data bundle between decode, the mux bank and execute.
interface mux_pipe_bank_if
  import mux_pipe_pkg::*;
#(
  parameter int unsigned NCH = 7,
  parameter int unsigned NIN = 2,
  parameter int unsigned W   = 12
);
  localparam int unsigned SELW = sel_width(NIN);

  logic                    in_valid;
  logic                    in_ready;
  logic [NCH*SELW-1:0]     sel;
  logic [NCH*NIN*W-1:0]    data;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [NCH*W-1:0]        out_data;
  logic [1:0]              occ;
  logic [NCH-1:0]          err_ch;
  logic                    clr_err;

  modport master (
    output in_valid, sel, data, flush, out_ready, clr_err,
    input  in_ready, out_valid, out_data, occ, err_ch
  );

  modport slave (
    input  in_valid, sel, data, flush, out_ready, clr_err,
    output in_ready, out_valid, out_data, occ, err_ch
  );
endinterface

// File: rtl/mux_pipe_bank_chan_sel.sv
// One channel: combinational NIN:1 select of W-bit sources with range error.
module mux_chan_sel
  import mux_pipe_pkg::*;
#(
  parameter int unsigned NIN  = 2,
  parameter int unsigned W    = 12,
  parameter int unsigned SELW = 1
) (
  input  logic [SELW-1:0]  sel_i,
  input  logic [NIN*W-1:0] src_i,
  output logic [W-1:0]     res_o,
  output logic             err_o
);
  logic [31:0] idx;

  // Out-of-range selects yield zero data and raise the error bit.
  always_comb begin
    err_o = (32'(sel_i) >= NIN);
    idx   = safe_sel(32'(sel_i), NIN);
    res_o = '0;
    for (int unsigned k = 0; k < NIN; k++) begin
      if (!err_o && idx == k) res_o = src_i[k*W +: W];
    end
  end
endmodule

// File: rtl/mux_pipe_bank.sv
// NCH-channel select bank behind a valid/ready stage with a one-beat skid.
module mux_pipe_bank
  import mux_pipe_pkg::*;
#(
  parameter int unsigned NCH = 7,
  parameter int unsigned NIN = 2,
  parameter int unsigned W   = 12
) (
  input  logic           Clk,
  input  logic           Reset_n,
  mux_pipe_bank_if.slave bus
);
  localparam int unsigned SELW = sel_width(NIN);

  logic [NCH*W-1:0] res;
  logic [NCH-1:0]   res_err;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    mux_chan_sel #(.NIN(NIN), .W(W), .SELW(SELW)) u_sel (
      .sel_i (bus.sel[c*SELW +: SELW]),
      .src_i (bus.data[c*NIN*W +: NIN*W]),
      .res_o (res[c*W +: W]),
      .err_o (res_err[c])
    );
  end

  occ_e             occ_q, occ_d;
  logic [NCH*W-1:0] m_q, m_d;
  logic [NCH*W-1:0] s_q, s_d;
  logic [NCH-1:0]   err_q, err_d;
  logic             live_q;
  logic             out_valid, in_ready, accept, pop;

  assign out_valid = (occ_q != OCC_EMPTY);
  // Ready depends only on registered state, never on out_ready.
  assign in_ready  = live_q && (occ_q != OCC_FULL);
  assign accept    = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;

  assign bus.out_valid = out_valid;
  assign bus.in_ready  = in_ready;
  assign bus.out_data  = m_q;
  assign bus.occ       = occ_q;
  assign bus.err_ch    = err_q;

  // Register occupancy, main/skid beats, sticky errors and post-reset ready.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      occ_q  <= OCC_EMPTY;
      m_q    <= '0;
      s_q    <= '0;
      err_q  <= '0;
      live_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      m_q    <= m_d;
      s_q    <= s_d;
      err_q  <= err_d;
      live_q <= 1'b1;
    end
  end

  // Next occupancy, beat movement between skid and main, error update.
  always_comb begin
    occ_d = occ_q;
    m_d   = m_q;
    s_d   = s_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (accept) begin
          m_d   = res;
          occ_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (accept && pop) begin
          m_d = res;
        end else if (accept) begin
          s_d   = res;
          occ_d = OCC_FULL;
        end else if (pop) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          m_d   = s_q;
          occ_d = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
    // Flush empties the bank but leaves M untouched so out_data holds.
    if (bus.flush) begin
      occ_d = OCC_EMPTY;
      m_d   = m_q;
      s_d   = s_q;
    end
    // A new error on an accepted, non-flushed beat outranks clr_err.
    err_d = (bus.clr_err ? '0 : err_q) | ((accept && !bus.flush) ? res_err : '0);
  end
endmodule
